// File: rtl/isa_pkg.sv
// Shared ISA definitions: mnemonic codes, opcode/funct constants and word width.
// Used by the program encoder and the control decoder.
package isa_pkg;

  localparam int WORD_W = 9;

  typedef enum logic [4:0] {
    OP_ADD     = 5'd0,
    OP_SUB     = 5'd1,
    OP_LD      = 5'd2,
    OP_ST      = 5'd3,
    OP_LB      = 5'd4,
    OP_SUBI    = 5'd5,
    OP_ADDI    = 5'd6,
    OP_BEQ     = 5'd7,
    OP_BNE     = 5'd8,
    OP_BLT     = 5'd9,
    OP_BLE     = 5'd10,
    OP_MOVTO   = 5'd11,
    OP_MOVFROM = 5'd12,
    OP_LSL     = 5'd13,
    OP_ASR     = 5'd14,
    OP_LSR     = 5'd15,
    OP_NOT     = 5'd16,
    OP_AND     = 5'd17,
    OP_XOR     = 5'd18,
    OP_RXOR    = 5'd19,
    OP_OR      = 5'd20
  } mnemonic_e;

  localparam logic [2:0] OPC_ALU  = 3'b000;
  localparam logic [2:0] OPC_LB   = 3'b001;
  localparam logic [2:0] OPC_SUBI = 3'b010;
  localparam logic [2:0] OPC_ADDI = 3'b011;
  localparam logic [2:0] OPC_BR   = 3'b100;
  localparam logic [2:0] OPC_MOV  = 3'b101;
  localparam logic [2:0] OPC_SH   = 3'b110;
  localparam logic [2:0] OPC_LOG  = 3'b111;

  localparam logic [1:0] FN_0 = 2'b00;
  localparam logic [1:0] FN_1 = 2'b01;
  localparam logic [1:0] FN_2 = 2'b10;
  localparam logic [1:0] FN_3 = 2'b11;

endpackage

// File: rtl/instr_pack.sv
// Combinational packing of instruction fields into a 9-bit word
// {opcode[8:6], funct[5:4], field[3:0]}; flags codes outside the mnemonic set.
module instr_pack
  import isa_pkg::*;
(
  input  logic [4:0]        op,
  input  logic [3:0]        rg,
  input  logic              sel,
  input  logic [4:0]        imm,
  output logic [WORD_W-1:0] word,
  output logic              illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:     word = {OPC_ALU, FN_0, rg};
      OP_SUB:     word = {OPC_ALU, FN_1, rg};
      OP_LD:      word = {OPC_ALU, FN_2, rg};
      OP_ST:      word = {OPC_ALU, FN_3, rg};
      OP_LB:      word = {OPC_LB, imm, sel};
      OP_SUBI:    word = {OPC_SUBI, imm, 1'b0};
      OP_ADDI:    word = {OPC_ADDI, imm, 1'b0};
      OP_BEQ:     word = {OPC_BR, FN_0, rg};
      OP_BNE:     word = {OPC_BR, FN_1, rg};
      OP_BLT:     word = {OPC_BR, FN_2, rg};
      OP_BLE:     word = {OPC_BR, FN_3, rg};
      // bit 5 distinguishes the move direction, bit 4 picks R0/R1
      OP_MOVTO:   word = {OPC_MOV, 1'b0, sel, rg};
      OP_MOVFROM: word = {OPC_MOV, 1'b1, sel, rg};
      OP_LSL:     word = {OPC_SH, FN_0, rg};
      OP_ASR:     word = {OPC_SH, FN_1, rg};
      OP_LSR:     word = {OPC_SH, FN_2, rg};
      OP_NOT:     word = {OPC_SH, FN_3, rg};
      OP_AND:     word = {OPC_LOG, FN_0, rg};
      OP_XOR:     word = {OPC_LOG, FN_1, rg};
      OP_RXOR:    word = {OPC_LOG, FN_2, rg};
      OP_OR:      word = {OPC_LOG, FN_3, rg};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_encoder.sv
// Program loader: accepts instruction fields over a valid/ready handshake,
// packs them and writes one word per cycle into instruction memory.
module program_encoder
  import isa_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [3:0]        in_reg,
  input  logic              in_sel,
  input  logic [4:0]        in_imm,
  output logic              im_we,
  output logic [AW-1:0]     im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic [AW:0]       count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE, S_ERR} state_e;

  localparam logic [AW-1:0] ADDR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW:0]       count_q, count_d;
  logic              we_q, we_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] word;
  logic              illegal;
  logic              xfer;
  logic              full;

  instr_pack u_pack (
    .op      (in_op),
    .rg      (in_reg),
    .sel     (in_sel),
    .imm     (in_imm),
    .word    (word),
    .illegal (illegal)
  );

  assign in_ready = (state_q == S_LOAD);
  assign xfer     = in_valid && in_ready;
  // count has one extra bit, so its MSB alone marks 2**AW words written
  assign full     = count_q[AW];
  assign busy     = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign im_we    = we_q;
  assign im_addr  = waddr_q;
  assign im_wdata = wdata_q;
  assign count    = count_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (xfer && (illegal || full)) begin
          state_d = S_ERR;
        end else begin
          if (xfer) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = word;
            addr_d  = addr_q + ADDR_ONE;
            count_d = count_q + CNT_ONE;
          end
          if (finish) state_d = S_DRAIN;
        end
      end
      // the last registered word is on the write port during this cycle
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_program_encoder.sv
// Directed bench for program_encoder: vector table of encodings plus
// hand-written sequences for finish, illegal, full and reset corner cases.
module tb_program_encoder;
  import isa_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       finish = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_op = '0;
  logic [3:0] in_reg = '0;
  logic       in_sel = 1'b0;
  logic [4:0] in_imm = '0;

  logic        in_ready, im_we, busy, done, err;
  logic [9:0]  im_addr;
  logic [8:0]  im_wdata;
  logic [10:0] count;

  logic        in_ready2, im_we2, busy2, done2, err2;
  logic [1:0]  im_addr2;
  logic [8:0]  im_wdata2;
  logic [2:0]  count2;

  int passed = 0;
  int total  = 0;

  program_encoder #(.AW(10)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_reg(in_reg),
    .in_sel(in_sel), .in_imm(in_imm), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .count(count), .busy(busy), .done(done), .err(err)
  );

  program_encoder #(.AW(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op), .in_reg(in_reg),
    .in_sel(in_sel), .in_imm(in_imm), .im_we(im_we2), .im_addr(im_addr2),
    .im_wdata(im_wdata2), .count(count2), .busy(busy2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic [3:0] rg;
    logic       sel;
    logic [4:0] imm;
    logic [8:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic [4:0] op, input logic [3:0] rg, input logic sel,
                       input logic [4:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_reg   = rg;
    in_sel   = sel;
    in_imm   = imm;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " im_we"},    32'(im_we),    0);
    check({tag, " im_addr"},  32'(im_addr),  0);
    check({tag, " im_wdata"}, 32'(im_wdata), 0);
    check({tag, " count"},    32'(count),    0);
    check({tag, " in_ready"}, 32'(in_ready), 0);
    check({tag, " busy"},     32'(busy),     0);
    check({tag, " done"},     32'(done),     0);
    check({tag, " err"},      32'(err),      0);
  endtask

  initial begin
    tbl[0]  = '{OP_ADDI,    4'd0,  1'b0, 5'd5,  9'h0CA};
    tbl[1]  = '{OP_MOVTO,   4'd7,  1'b1, 5'd0,  9'h157};
    tbl[2]  = '{OP_BNE,     4'd9,  1'b0, 5'd0,  9'h119};
    tbl[3]  = '{OP_ST,      4'd3,  1'b0, 5'd0,  9'h033};
    tbl[4]  = '{OP_LB,      4'd0,  1'b1, 5'd12, 9'h059};
    tbl[5]  = '{OP_ADD,     4'd2,  1'b1, 5'd31, 9'h002};
    tbl[6]  = '{OP_SUB,     4'd5,  1'b0, 5'd0,  9'h015};
    tbl[7]  = '{OP_LD,      4'd15, 1'b0, 5'd0,  9'h02F};
    tbl[8]  = '{OP_SUBI,    4'd9,  1'b1, 5'd31, 9'h0BE};
    tbl[9]  = '{OP_BEQ,     4'd0,  1'b0, 5'd0,  9'h100};
    tbl[10] = '{OP_BLT,     4'd4,  1'b0, 5'd0,  9'h124};
    tbl[11] = '{OP_BLE,     4'd15, 1'b0, 5'd0,  9'h13F};
    tbl[12] = '{OP_MOVFROM, 4'd3,  1'b0, 5'd0,  9'h163};
    tbl[13] = '{OP_LSL,     4'd1,  1'b0, 5'd0,  9'h181};
    tbl[14] = '{OP_ASR,     4'd2,  1'b0, 5'd0,  9'h192};
    tbl[15] = '{OP_LSR,     4'd3,  1'b0, 5'd0,  9'h1A3};
    tbl[16] = '{OP_NOT,     4'd4,  1'b0, 5'd0,  9'h1B4};
    tbl[17] = '{OP_AND,     4'd5,  1'b0, 5'd0,  9'h1C5};
    tbl[18] = '{OP_RXOR,    4'd7,  1'b0, 5'd0,  9'h1E7};
    tbl[19] = '{OP_LB,      4'd0,  1'b0, 5'd0,  9'h040};

    // reset state, observed while reset is held
    #12;
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // finish outside LOAD is ignored
    finish = 1'b1;
    tick();
    finish = 1'b0;
    check("idle finish busy", 32'(busy), 0);
    check("idle finish done", 32'(done), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("start busy", 32'(busy), 1);
    check("start in_ready", 32'(in_ready), 1);
    check("start count", 32'(count), 0);
    check("start im_we", 32'(im_we), 0);

    // back-to-back table, each word visible one cycle after its transfer
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].op, tbl[i].rg, tbl[i].sel, tbl[i].imm);
      tick();
      check($sformatf("vec%0d im_we", i), 32'(im_we), 1);
      check($sformatf("vec%0d im_addr", i), 32'(im_addr), i);
      check($sformatf("vec%0d im_wdata", i), 32'(im_wdata), 32'(tbl[i].exp));
      check($sformatf("vec%0d count", i), 32'(count), i + 1);
    end
    in_valid = 1'b0;
    tick();
    check("gap im_we", 32'(im_we), 0);
    check("gap count", 32'(count), NV);

    // finish together with a transfer: word still written, then DONE
    drive(OP_OR, 4'd8, 1'b0, 5'd0);
    finish = 1'b1;
    tick();
    in_valid = 1'b0;
    finish = 1'b0;
    check("fin im_we", 32'(im_we), 1);
    check("fin im_wdata", 32'(im_wdata), 'h1F8);
    check("fin im_addr", 32'(im_addr), NV);
    check("fin busy", 32'(busy), 1);
    check("fin in_ready", 32'(in_ready), 0);
    tick();
    check("drain im_we", 32'(im_we), 0);
    check("done flag", 32'(done), 1);
    check("done busy", 32'(busy), 0);
    check("done count", 32'(count), NV + 1);

    // start wins over finish; count restarts
    start = 1'b1;
    finish = 1'b1;
    tick();
    start = 1'b0;
    finish = 1'b0;
    check("restart busy", 32'(busy), 1);
    check("restart done", 32'(done), 0);
    check("restart count", 32'(count), 0);

    // start during LOAD is ignored
    drive(OP_ADD, 4'd1, 1'b0, 5'd0);
    start = 1'b1;
    tick();
    drive(OP_SUB, 4'd1, 1'b0, 5'd0);
    tick();
    start = 1'b0;
    check("load start addr", 32'(im_addr), 1);
    check("load start wdata", 32'(im_wdata), 'h011);
    check("load start count", 32'(count), 2);

    // illegal mnemonic
    drive(5'd31, 4'd0, 1'b0, 5'd0);
    tick();
    in_valid = 1'b0;
    check("illegal err", 32'(err), 1);
    check("illegal im_we", 32'(im_we), 0);
    check("illegal count", 32'(count), 2);
    check("illegal in_ready", 32'(in_ready), 0);
    check("illegal busy", 32'(busy), 0);
    tick();
    check("illegal im_we later", 32'(im_we), 0);

    // AW=2 instance: four writes fill it, fifth transfer errors
    start = 1'b1;
    tick();
    start = 1'b0;
    check("aw2 start count", 32'(count2), 0);
    for (int i = 0; i < 4; i++) begin
      drive(OP_ADD, 4'(i), 1'b0, 5'd0);
      tick();
      check($sformatf("aw2 w%0d im_we", i), 32'(im_we2), 1);
      check($sformatf("aw2 w%0d im_addr", i), 32'(im_addr2), i);
      check($sformatf("aw2 w%0d im_wdata", i), 32'(im_wdata2), i);
    end
    drive(OP_ADD, 4'd4, 1'b0, 5'd0);
    tick();
    in_valid = 1'b0;
    check("aw2 full err", 32'(err2), 1);
    check("aw2 full im_we", 32'(im_we2), 0);
    check("aw2 full count", 32'(count2), 4);
    check("aw2 full in_ready", 32'(in_ready2), 0);
    check("aw1024 not full", 32'(err), 0);

    // reset while a write is on the port
    tick();
    drive(OP_ADD, 4'd2, 1'b0, 5'd0);
    tick();
    check("pre-reset im_we", 32'(im_we), 1);
    reset = 1'b1;
    #1;
    check_all_zero("async reset");
    tick();
    reset = 1'b0;
    check("post-reset im_we", 32'(im_we), 0);
    tick();
    check("post-reset im_we2", 32'(im_we), 0);
    check("post-reset busy", 32'(busy), 0);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/program_encoder.md
PROGRAM_ENCODER -- requirements
Module: program_encoder

Interface
REQ-001 SHALL have parameter AW, default 10, meaning the instruction-memory address width (capacity 2**AW words).
REQ-002 SHALL have port clk  input  1  the single clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins a program load at address 0.
REQ-005 SHALL have port finish  input  1  one-cycle pulse that ends the load.
REQ-006 SHALL have ports in_valid  input  1 and in_ready  output  1  forming the instruction-field handshake.
REQ-007 SHALL have port in_op  input  5  mnemonic code from the shared mnemonic enum.
REQ-008 SHALL have port in_reg  input  4  register, destination or branch-target field.
REQ-009 SHALL have port in_sel  input  1  R0/R1 selector for lb and mov.
REQ-010 SHALL have port in_imm  input  5  immediate or LUT index.
REQ-011 SHALL have ports im_we  output  1, im_addr  output  AW and im_wdata  output  9  forming the instruction-memory write port.
REQ-012 SHALL have port count  output  AW+1  number of words written.
REQ-013 SHALL have ports busy, done and err  output  1 each, the status flags.

Function
REQ-014 SHALL implement a state machine with the states IDLE, LOAD, DRAIN, DONE and ERR.
REQ-015 SHALL move from IDLE, DONE or ERR to LOAD on start, and SHALL clear count and the address counter when it does.
REQ-016 SHALL drive in_ready=1 only in LOAD; a transfer is defined as in_valid&&in_ready.
REQ-017 SHALL register each transfer's word into the output stage, and SHALL assert im_we for exactly one cycle on the next cycle (latency 1, throughput 1 word/cycle).
REQ-018 SHALL write each word at the address counter and then increment both the address counter and count.
REQ-019 SHALL place opcode in word bits [8:6], funct in [5:4] and field in [3:0].
REQ-020 SHALL encode add/sub/ld/st as 000, funct 00/01/10/11, with [3:0]=in_reg.
REQ-021 SHALL encode lb as 001, [5:1]=in_imm, [0]=in_sel.
REQ-022 SHALL encode subi as 010 and addi as 011, with [5:1]=in_imm and [0]=0.
REQ-023 SHALL encode beq/bne/blt/ble as 100, funct 00/01/10/11, with [3:0]=in_reg as the target.
REQ-024 SHALL encode mov-to-Rsel as 101 with [5]=0, [4]=in_sel and [3:0]=in_reg (the source).
REQ-025 SHALL encode mov-from-Rsel as 101 with [5]=1, [4]=in_sel and [3:0]=in_reg (the destination).
REQ-026 SHALL encode lsl/asr/lsr/not as 110, funct 00..11, and and/xor/rxor/or as 111, funct 00..11, with [3:0]=in_reg.
REQ-027 SHALL treat any in_op outside the enum as illegal: the state goes to ERR, nothing is written and count is unchanged.
REQ-028 SHALL go to ERR without writing when a transfer arrives after 2**AW words have been written (full).
REQ-029 SHALL go to DRAIN on finish in LOAD; a transfer in that same cycle is still accepted and written.
REQ-030 SHALL go from DRAIN to DONE once the pending write has issued.
REQ-031 SHALL drive busy=1 in LOAD and DRAIN, done=1 in DONE and err=1 in ERR.
REQ-032 SHALL give start priority over finish in the same cycle.
REQ-033 SHALL ignore start while in LOAD or DRAIN.
REQ-034 SHALL ignore finish outside LOAD.

Reset
REQ-035 SHALL asynchronously, on reset=1, force the IDLE state and set im_we=0, im_addr=0, im_wdata=0, count=0, in_ready=0, busy=0, done=0 and err=0.
REQ-036 SHALL on reset during LOAD drop any pending write, so that no im_we pulse occurs after reset.

Structure
REQ-037 SHALL take the mnemonic enum, the opcode and funct constants and the 9-bit word width from a shared package, isa_pkg, which is also used by the control decoder.
REQ-038 SHALL place the field packing in one combinational sub-module, instr_pack, with inputs op/reg/sel/imm and outputs word and illegal.

Verification
REQ-039 SHALL cover: start; addi imm=5 -> im_wdata=0x0CA at addr 0 one cycle later, count=1.
REQ-040 SHALL cover: mov-to-R1 from R7 -> 0x157; bne target 9 -> 0x119; st reg 3 -> 0x033; lb idx 12 to R1 -> 0x059, at consecutive addresses.
REQ-041 SHALL cover: AW=2 with 5 back-to-back transfers -> writes at addr 0..3, fifth causes err=1, count=4, in_ready=0.
REQ-042 SHALL cover: in_op=31 (illegal) -> err=1, no im_we.
REQ-043 SHALL cover: finish in the same cycle as a transfer -> that word is written, then done=1.
REQ-044 SHALL cover: reset asserted while a write is pending -> all outputs 0 immediately, no im_we afterwards.
